// File: rtl/lda_pkg.sv
// Shared types and constants for the line-draw accelerator: register map,
// FSM states and the packed screen point used by the register file and datapath.
package lda_pkg;

   localparam int unsigned X_WIDTH   = 9;
   localparam int unsigned Y_WIDTH   = 8;
   localparam int unsigned COL_WIDTH = 3;

   localparam logic [2:0] ADDR_MODE   = 3'd0;
   localparam logic [2:0] ADDR_STATUS = 3'd1;
   localparam logic [2:0] ADDR_GO     = 3'd2;
   localparam logic [2:0] ADDR_START  = 3'd3;
   localparam logic [2:0] ADDR_END    = 3'd4;
   localparam logic [2:0] ADDR_COLOUR = 3'd5;

   typedef enum logic [1:0] {StIdle, StSetup, StDraw, StDone} state_t;

   typedef struct packed {
      logic [X_WIDTH-1:0] x;
      logic [Y_WIDTH-1:0] y;
   } point_t;

   // Register image of a point: [8:0]=x, [16:9]=y, upper bits zero.
   function automatic logic [31:0] pack_point(point_t p);
      return {{(32 - X_WIDTH - Y_WIDTH){1'b0}}, p.y, p.x};
   endfunction

endpackage

// File: rtl/lda_bresenham.sv
// Bresenham line engine: one SETUP cycle to normalise the endpoints, then one
// pixel per cycle from the low to the high end of the major axis.
module lda_bresenham
   import lda_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  point_t               p0,
   input  point_t               p1,
   input  logic [COL_WIDTH-1:0] colour,
   output logic                 busy,
   output logic                 done,
   output logic [X_WIDTH-1:0]   x,
   output logic [Y_WIDTH-1:0]   y,
   output logic [COL_WIDTH-1:0] pix_colour,
   output logic                 plot
);

   localparam int unsigned ErrW = X_WIDTH + 2;
   typedef logic [X_WIDTH-1:0] coord_t;

   state_t                 state_q;
   logic                   steep_q;
   logic                   ystep_neg_q;
   coord_t                 cur_a_q, cur_b_q, end_a_q, dx_q, dy_q;
   logic signed [ErrW-1:0] err_q;
   logic [COL_WIDTH-1:0]   colour_q;

   coord_t x0e, y0e, x1e, y1e, adx, ady;
   coord_t a0, b0, a1, b1, sa0, sb0, sa1, sb1, dx_w, dy_w;
   logic   steep, swap;
   logic signed [ErrW-1:0] err_step;
   logic   err_pos;

   // Endpoint normalisation: a is the major axis, b the minor one.
   always_comb begin
      x0e   = p0.x;
      x1e   = p1.x;
      y0e   = coord_t'(p0.y);
      y1e   = coord_t'(p1.y);
      adx   = (x1e >= x0e) ? x1e - x0e : x0e - x1e;
      ady   = (y1e >= y0e) ? y1e - y0e : y0e - y1e;
      steep = ady > adx;
      a0    = steep ? y0e : x0e;
      b0    = steep ? x0e : y0e;
      a1    = steep ? y1e : x1e;
      b1    = steep ? x1e : y1e;
      swap  = a0 > a1;
      sa0   = swap ? a1 : a0;
      sb0   = swap ? b1 : b0;
      sa1   = swap ? a0 : a1;
      sb1   = swap ? b0 : b1;
      dx_w  = sa1 - sa0;
      dy_w  = (sb1 >= sb0) ? sb1 - sb0 : sb0 - sb1;
   end

   always_comb begin
      err_step = err_q + $signed({2'b00, dy_q});
      err_pos  = !err_step[ErrW-1] && (err_step != '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         steep_q     <= 1'b0;
         ystep_neg_q <= 1'b0;
         cur_a_q     <= '0;
         cur_b_q     <= '0;
         end_a_q     <= '0;
         dx_q        <= '0;
         dy_q        <= '0;
         err_q       <= '0;
         colour_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) state_q <= StSetup;
            end
            StSetup: begin
               steep_q     <= steep;
               ystep_neg_q <= sb1 < sb0;
               cur_a_q     <= sa0;
               cur_b_q     <= sb0;
               end_a_q     <= sa1;
               dx_q        <= dx_w;
               dy_q        <= dy_w;
               err_q       <= -$signed({3'b000, dx_w[X_WIDTH-1:1]});
               colour_q    <= colour;
               state_q     <= StDraw;
            end
            StDraw: begin
               if (cur_a_q == end_a_q) begin
                  state_q <= StDone;
               end else begin
                  cur_a_q <= cur_a_q + coord_t'(1);
                  if (err_pos) begin
                     cur_b_q <= ystep_neg_q ? cur_b_q - coord_t'(1) : cur_b_q + coord_t'(1);
                     err_q   <= err_step - $signed({2'b00, dx_q});
                  end else begin
                     err_q <= err_step;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      busy       = (state_q == StSetup) || (state_q == StDraw);
      done       = state_q == StDone;
      plot       = state_q == StDraw;
      x          = steep_q ? cur_b_q : cur_a_q;
      y          = steep_q ? cur_a_q[Y_WIDTH-1:0] : cur_b_q[Y_WIDTH-1:0];
      pix_colour = colour_q;
   end

endmodule

// File: rtl/lda_line_accel.sv
// Avalon-MM line-draw peripheral: register file, GO handshake (stall or poll)
// and screen clipping around the Bresenham engine.
module lda_line_accel
   import lda_pkg::*;
#(
   parameter int unsigned SCR_W = 336,
   parameter int unsigned SCR_H = 210,
   parameter int unsigned X_W   = X_WIDTH,
   parameter int unsigned Y_W   = Y_WIDTH,
   parameter int unsigned COL_W = COL_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             avs_waitrequest,
   output logic [X_W-1:0]   vga_x,
   output logic [Y_W-1:0]   vga_y,
   output logic [COL_W-1:0] vga_colour,
   output logic             vga_plot
);

   localparam logic [X_W-1:0] XLim = X_W'(SCR_W);
   localparam logic [Y_W-1:0] YLim = Y_W'(SCR_H);

   logic                 mode_q;
   logic                 line_stall_q;
   point_t               start_q, end_q;
   logic [COL_WIDTH-1:0] colour_q;

   logic                 busy, done, idle, go_wr, line_start, pix_plot;
   logic [X_WIDTH-1:0]   pix_x;
   logic [Y_WIDTH-1:0]   pix_y;
   logic [COL_WIDTH-1:0] pix_colour;

   logic unused_bus;
   assign unused_bus = ^{avs_read, avs_writedata[31:X_WIDTH+Y_WIDTH]};

   always_comb begin
      idle       = !busy && !done;
      go_wr      = avs_write && (avs_address == ADDR_GO);
      line_start = idle && go_wr;
      // A stall-mode GO is held from its first cycle until the engine reaches DONE.
      avs_waitrequest = go_wr && ((idle && !mode_q) || (busy && line_stall_q));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q       <= 1'b0;
         line_stall_q <= 1'b0;
         start_q      <= '0;
         end_q        <= '0;
         colour_q     <= '0;
      end else begin
         if (line_start) line_stall_q <= !mode_q;
         if (avs_write) begin
            case (avs_address)
               ADDR_MODE:   mode_q   <= avs_writedata[0];
               ADDR_START:  start_q  <= '{x: avs_writedata[X_WIDTH-1:0],
                                          y: avs_writedata[X_WIDTH+Y_WIDTH-1:X_WIDTH]};
               ADDR_END:    end_q    <= '{x: avs_writedata[X_WIDTH-1:0],
                                          y: avs_writedata[X_WIDTH+Y_WIDTH-1:X_WIDTH]};
               ADDR_COLOUR: colour_q <= avs_writedata[COL_WIDTH-1:0];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      avs_readdata = '0;
      case (avs_address)
         ADDR_MODE:   avs_readdata[0] = mode_q;
         ADDR_STATUS: avs_readdata[0] = busy;
         ADDR_START:  avs_readdata = pack_point(start_q);
         ADDR_END:    avs_readdata = pack_point(end_q);
         ADDR_COLOUR: avs_readdata[COL_WIDTH-1:0] = colour_q;
         default: ;
      endcase
   end

   lda_bresenham u_bresenham (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (line_start),
      .p0         (start_q),
      .p1         (end_q),
      .colour     (colour_q),
      .busy       (busy),
      .done       (done),
      .x          (pix_x),
      .y          (pix_y),
      .pix_colour (pix_colour),
      .plot       (pix_plot)
   );

   // Off-screen pixels still take their DRAW cycle; only the strobe is suppressed.
   always_comb begin
      vga_x      = pix_x;
      vga_y      = pix_y;
      vga_colour = pix_colour;
      vga_plot   = pix_plot && (pix_x < XLim) && (pix_y < YLim);
   end

endmodule

// File: doc/lda_line_accel.md
Name: lda_line_accel

Overview:
- Avalon-MM slave peripheral on the Nios II bus that draws straight lines into the VGA pixel path with Bresenham's algorithm.
- Software loads the endpoints and a colour, then writes GO.
- The block emits one pixel write per cycle (x, y, colour, plot strobe) to the VGA framebuffer adapter, which drives the vga_* exports of nios_system.
- Two completion modes: stall (bus held until the line is done) and poll (software reads STATUS).

Parameters:
- SCR_W, 336: visible screen width in pixels.
- SCR_H, 210: visible screen height in pixels.
- X_W, 9: x coordinate width.
- Y_W, 8: y coordinate width.
- COL_W, 3: colour width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- avs_address  in  3  word address of the register
- avs_read  in  1  Avalon read strobe
- avs_write  in  1  Avalon write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, zero read latency
- avs_waitrequest  out  1  stall strobe
- vga_x  out  X_W  pixel x
- vga_y  out  Y_W  pixel y
- vga_colour  out  COL_W  pixel colour
- vga_plot  out  1  pixel write strobe, one pixel per asserted cycle

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous assert, active-low.
- Reset values:
  - All outputs 0; FSM in IDLE.
  - MODE=0, START=0, END=0, COLOUR=0.
- Register map (32-bit words; unused bits read 0):
  - 0 MODE, R/W, bit0: 0=stall, 1=poll.
  - 1 STATUS, RO, bit0=busy; writes ignored.
  - 2 GO, WO, any write starts a line; reads 0.
  - 3 START, R/W: [8:0]=x0, [16:9]=y0.
  - 4 END, R/W: [8:0]=x1, [16:9]=y1.
  - 5 COLOUR, R/W: [2:0].
  - 6–7 reserved: read 0, writes ignored.
- Reads: avs_readdata is combinational from the registers; waitrequest is never raised for reads.
- FSM states: IDLE, SETUP, DRAW, DONE.
- IDLE -> SETUP on an accepted GO write.
- SETUP (1 cycle), latches from the shadow registers:
  - steep = |y1-y0| > |x1-x0|; if steep, swap x/y of both points.
  - If x0 > x1, swap the points.
  - dx = x1-x0, dy = |y1-y0|.
  - err = -(dx>>1), signed, X_W+2 bits.
  - ystep = +1/-1; colour latched.
- DRAW (dx+1 cycles, x = x0..x1 inclusive):
  - Each cycle present (steep ? (y,x) : (x,y)) on vga_x/vga_y and colour on vga_colour.
  - err += dy; if the new err > 0 then y += ystep and err -= dx.
  - After the x1 pixel -> DONE.
- DONE (1 cycle) -> IDLE. Busy = state != IDLE and != DONE.
- vga_plot = 1 in DRAW only, and only if the plotted x < SCR_W and y < SCR_H. Off-screen pixels still consume a cycle but are not written.
- Stall mode:
  - A GO write raises waitrequest combinationally in the cycle it is presented, and holds it through SETUP and DRAW.
  - Waitrequest drops in DONE; the GO transfer completes there.
  - Total waitrequest-high cycles = dx+3.
- Poll mode:
  - GO is accepted with waitrequest=0.
  - GO while busy is ignored.
  - START/END/COLOUR/MODE writes while busy update the shadow registers only; the active line uses values latched in SETUP.
- A MODE change takes effect on the next GO.
- Degenerate line (x0=x1, y0=y1): exactly one pixel.
- Reset mid-line: immediate return to IDLE, vga_plot=0, waitrequest=0, registers to reset values.

Decomposition:
- Package lda_pkg:
  - Register address constants (ADDR_MODE..ADDR_COLOUR).
  - state_t enum {IDLE, SETUP, DRAW, DONE}.
  - Coordinate/colour widths.
  - Typedef point_t {x, y}.
- Sub-module lda_bresenham: SETUP/DRAW datapath and FSM.
  - Inputs: start, p0, p1, colour.
  - Outputs: busy, done, x, y, colour, plot.
- Top level lda_line_accel holds the Avalon register file, the waitrequest logic and the screen clip.

Test Plan:
1. Stall horizontal: MODE=0, START=(0,0), END=(4,0), COLOUR=5, GO at cycle T -> waitrequest high T..T+6, vga_plot at T+2..T+6 with x=0,1,2,3,4, y=0, colour=5; waitrequest low at T+7.
2. Steep: (2,1)->(4,7) -> exactly 7 plots in order (2,1),(2,2),(3,3),(3,4),(3,5),(4,6),(4,7).
3. Reversed: (4,0)->(0,0) -> 5 plots x=0..4, y=0; single point (10,10)->(10,10) -> exactly 1 plot at (10,10), waitrequest high 3 cycles.
4. Poll mode:
   - MODE=1, (0,0)->(9,3), GO -> waitrequest never high.
   - STATUS reads 1 during DRAW and 0 after the 10th plot.
   - A second GO plus an END=(0,50) write mid-line do not alter the 10 plotted pixels.
5. Clip: (333,5)->(337,5) -> 5 DRAW cycles, vga_plot only for x=333,334,335.
6. Reset: assert reset_n=0 during DRAW of (0,0)->(20,0) -> same-cycle vga_plot=0, waitrequest=0, STATUS=0, MODE/START/END/COLOUR read 0 after release.
